// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
//  - F3M_* : funct3 encodings of the RV64M divide/remainder family.
//  - Div_State : divider control states.
package div_unit_pkg;

  localparam logic [2:0] F3M_DIV  = 3'b100;
  localparam logic [2:0] F3M_DIVU = 3'b101;
  localparam logic [2:0] F3M_REM  = 3'b110;
  localparam logic [2:0] F3M_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } Div_State;

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract division step (combinational).
// Ports:
//  rem_i     partial remainder, always < divisor_i
//  quo_i     dividend bits still to consume (MSB first) / quotient bits so far
//  divisor_i divisor magnitude
//  rem_o     next partial remainder
//  quo_o     quo_i shifted left with the new quotient bit in the LSB
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (shifted >= {1'b0, divisor_i}) begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_o = shifted[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle iterative divider for RV64M DIV/DIVU/REM/REMU and the -W forms.
// Ports:
//  clk, reset        clock, synchronous active-high reset
//  flush             abandon any in-flight operation
//  req_*             request channel (valid/ready), operands, funct3, W flag, tag
//  resp_*            response channel (valid/ready), result, echoed tag
//  busy              high whenever the unit is not idle
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [2:0]       req_funct3,
  input  logic             req_width_32,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

  Div_State         state_q;
  logic [CNT_W-1:0] count_q;
  logic [XLEN-1:0]  rem_q, quo_q, div_q, result_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_quo_q, neg_rem_q, is_rem_q, w32_q;

  // Sign-extend from bit 31 for W results.
  function automatic logic [XLEN-1:0] fit_w(input logic [XLEN-1:0] v, input logic w32);
    fit_w = w32 ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Request operand preparation.
  logic                   sgn_op, is_rem, div_zero, overflow;
  logic signed [XLEN-1:0] a_op, b_op;
  logic [XLEN-1:0]        a_mag, b_mag, special_res;

  always_comb begin
    sgn_op = ~req_funct3[0];
    is_rem = req_funct3[1];
    if (req_width_32) begin
      a_op = sgn_op ? {{(XLEN-32){req_a[31]}}, req_a[31:0]} : {{(XLEN-32){1'b0}}, req_a[31:0]};
      b_op = sgn_op ? {{(XLEN-32){req_b[31]}}, req_b[31:0]} : {{(XLEN-32){1'b0}}, req_b[31:0]};
    end else begin
      a_op = req_a;
      b_op = req_b;
    end
    a_mag    = (sgn_op && a_op[XLEN-1]) ? -a_op : a_op;
    b_mag    = (sgn_op && b_op[XLEN-1]) ? -b_op : b_op;
    div_zero = (b_op == '0);
    overflow = sgn_op && (b_op == '1) && (a_op == (req_width_32 ? MIN_W : MIN_X));
    if (div_zero)
      special_res = is_rem ? fit_w(a_op, req_width_32) : '1;
    else
      special_res = is_rem ? '0 : fit_w(a_op, req_width_32);
  end

  // Iteration datapath and final sign fixup.
  logic [XLEN-1:0] rem_nx, quo_nx, raw_res, signed_res;

  div_step #(.W(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (rem_nx),
    .quo_o     (quo_nx)
  );

  always_comb begin
    raw_res    = is_rem_q ? rem_nx : quo_nx;
    signed_res = (is_rem_q ? neg_rem_q : neg_quo_q) ? -raw_res : raw_res;
  end

  // Control FSM with datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (flush) begin
      // Also drops a request presented in the same IDLE cycle.
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          tag_q     <= req_tag;
          is_rem_q  <= is_rem;
          w32_q     <= req_width_32;
          neg_quo_q <= sgn_op && (a_op[XLEN-1] ^ b_op[XLEN-1]);
          neg_rem_q <= sgn_op && a_op[XLEN-1];
          if (!req_funct3[2]) begin
            result_q <= XLEN'(64'hDEADBEEF);
            state_q  <= DONE;
          end else if (div_zero || overflow) begin
            result_q <= special_res;
            state_q  <= DONE;
          end else begin
            rem_q   <= '0;
            // W dividends sit in the upper half so their MSB is consumed first.
            quo_q   <= req_width_32 ? (a_mag << 32) : a_mag;
            div_q   <= b_mag;
            count_q <= req_width_32 ? CNT_W'(32) : CNT_W'(XLEN);
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q   <= rem_nx;
          quo_q   <= quo_nx;
          count_q <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            result_q <= fit_w(signed_res, w32_q);
            state_q  <= DONE;
          end
        end
        DONE: if (resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && req_valid && state_q == IDLE)
      assert (req_funct3[2]) else $error("div_unit: MUL-family funct3 %b issued", req_funct3);
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_result = result_q;
  assign resp_tag    = tag_q;

endmodule
